pixel_collision_detector: RTL and testbench

Pixel-accurate bird/pipe collision detector for the Flappy VGA game. It sits directly downstream of the sync generator, flight physics and pipe position logic, and upstream of the VGA colour output registers. Per pixel it produces the registered bird and pipe coverage bits. It also counts bird/pipe overlap pixels over each frame and raises a one-hot game state plus a Lose pulse when a frame's overlap count reaches a threshold.

---
 rtl/flappy_pkg.sv | 39 +++
 rtl/pixel_collision_detector_pipe_hit.sv | 24 ++
 rtl/pixel_collision_detector.sv | 181 ++++++++++++++++++
 tb/tb_pixel_collision_detector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared constants, state encoding and clamp helpers for the
// Flappy VGA game blocks.
//   H_MAX/V_MAX     last visible column/row (clamp limits)
//   BIRD_HALF       bird box half-size
//   PIPE_W          pipe width added to the pipe left edge
//   NPIPE           number of pipes carried on the packed pipe buses
//   QI/QA/QL        one-hot state codes (idle / armed / lose)
package flappy_pkg;

    localparam int H_MAX     = 639;
    localparam int V_MAX     = 479;
    localparam int BIRD_HALF = 10;
    localparam int PIPE_W    = 80;
    localparam int NPIPE     = 4;

    localparam logic [2:0] QI = 3'b001;
    localparam logic [2:0] QA = 3'b010;
    localparam logic [2:0] QL = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = QI,
        ST_ARMED = QA,
        ST_LOSE  = QL
    } state_t;

    // a - b, floored at zero
    function automatic logic [10:0] sub_floor0(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : 11'd0;
    endfunction

    // a + b, capped at lim (operands are small enough that the sum fits 11 bits)
    function automatic logic [10:0] add_clamp(input logic [10:0] a, input logic [10:0] b,
                                              input logic [10:0] lim);
        logic [10:0] s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/pixel_collision_detector_pipe_hit.sv
// pipe_hit: combinational coverage test of one pipe against the current pixel.
//   x, y        current pixel column/row
//   left,right  inclusive horizontal bounds (right already clamped)
//   bot, top    inclusive vertical bounds; bot > top yields no coverage
//   hit         pixel lies inside the pipe
module pipe_hit (
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [10:0] left,
    input  logic [10:0] right,
    input  logic [10:0] bot,
    input  logic [10:0] top,
    output logic        hit
);

    logic [10:0] x_ext;
    logic [10:0] y_ext;

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};
    assign hit   = (x_ext >= left) && (x_ext <= right) &&
                   (y_ext >= bot)  && (y_ext <= top);

endmodule

// File: rtl/pixel_collision_detector.sv
// pixel_collision_detector: per-pixel bird/pipe coverage plus a per-frame
// overlap counter that drives the armed/lose game state.
//   Clk, Reset            clock; asynchronous active-high reset
//   Start, Ack            arm detection / leave the lose state (pulses)
//   Frame_Start           once-per-frame pulse in vertical blanking
//   inDisplayArea         current pixel is visible
//   CounterX/Y            current pixel position
//   Bird_X/Y              bird centre
//   Pipe_X/Top/Bot        four packed 10-bit pipe bounds (pipe i at [10i+9:10i])
//   Bird_Px, Pipe_Px      registered coverage bits (1-cycle lag)
//   Hit_Count             overlap count of the last completed frame
//   Lose_Pulse            one cycle on entry to lose
//   Q_Idle/Q_Armed/Q_Lose one-hot state
module pixel_collision_detector #(
    parameter int H_MAX      = flappy_pkg::H_MAX,
    parameter int V_MAX      = flappy_pkg::V_MAX,
    parameter int BIRD_HALF  = flappy_pkg::BIRD_HALF,
    parameter int PIPE_W     = flappy_pkg::PIPE_W,
    parameter int HIT_THRESH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic        Frame_Start,
    input  logic        inDisplayArea,
    input  logic [9:0]  CounterX,
    input  logic [9:0]  CounterY,
    input  logic [9:0]  Bird_X,
    input  logic [9:0]  Bird_Y,
    input  logic [39:0] Pipe_X,
    input  logic [39:0] Pipe_Top,
    input  logic [39:0] Pipe_Bot,
    output logic        Bird_Px,
    output logic        Pipe_Px,
    output logic [7:0]  Hit_Count,
    output logic        Lose_Pulse,
    output logic        Q_Idle,
    output logic        Q_Armed,
    output logic        Q_Lose
);
    import flappy_pkg::*;

    state_t                 state_q, state_d;
    logic [10:0]            bird_l_q, bird_l_d, bird_r_q, bird_r_d;
    logic [10:0]            bird_t_q, bird_t_d, bird_b_q, bird_b_d;
    logic [NPIPE-1:0][10:0] pipe_l_q, pipe_l_d, pipe_r_q, pipe_r_d;
    logic [NPIPE-1:0][10:0] pipe_b_q, pipe_b_d, pipe_t_q, pipe_t_d;
    logic [NPIPE-1:0]       pipe_hit_vec;
    logic                   bird_px_q, bird_px_d, pipe_px_q, pipe_px_d;
    logic [7:0]             count_q, count_d, hit_q, hit_d;
    logic                   fv_q, fv_d, lose_q, lose_d;
    logic [10:0]            x_ext, y_ext;

    assign x_ext = {1'b0, CounterX};
    assign y_ext = {1'b0, CounterY};

    // Shadow bounds: clamped once at latch time so the per-pixel compare is
    // a plain inclusive window test.
    always_comb begin
        bird_l_d = bird_l_q;
        bird_r_d = bird_r_q;
        bird_t_d = bird_t_q;
        bird_b_d = bird_b_q;
        pipe_l_d = pipe_l_q;
        pipe_r_d = pipe_r_q;
        pipe_b_d = pipe_b_q;
        pipe_t_d = pipe_t_q;
        if (Frame_Start) begin
            bird_l_d = sub_floor0({1'b0, Bird_X}, 11'(BIRD_HALF));
            bird_r_d = add_clamp({1'b0, Bird_X}, 11'(BIRD_HALF), 11'(H_MAX));
            bird_t_d = sub_floor0({1'b0, Bird_Y}, 11'(BIRD_HALF));
            bird_b_d = add_clamp({1'b0, Bird_Y}, 11'(BIRD_HALF), 11'(V_MAX));
            for (int i = 0; i < NPIPE; i++) begin
                pipe_l_d[i] = {1'b0, Pipe_X[10*i +: 10]};
                pipe_r_d[i] = add_clamp({1'b0, Pipe_X[10*i +: 10]}, 11'(PIPE_W), 11'(H_MAX));
                pipe_b_d[i] = {1'b0, Pipe_Bot[10*i +: 10]};
                pipe_t_d[i] = {1'b0, Pipe_Top[10*i +: 10]};
            end
        end
    end

    for (genvar g = 0; g < NPIPE; g++) begin : g_pipe
        pipe_hit u_pipe_hit (
            .x     (CounterX),
            .y     (CounterY),
            .left  (pipe_l_q[g]),
            .right (pipe_r_q[g]),
            .bot   (pipe_b_q[g]),
            .top   (pipe_t_q[g]),
            .hit   (pipe_hit_vec[g])
        );
    end

    always_comb begin
        bird_px_d = inDisplayArea &&
                    (x_ext >= bird_l_q) && (x_ext <= bird_r_q) &&
                    (y_ext >= bird_t_q) && (y_ext <= bird_b_q);
        pipe_px_d = inDisplayArea && (|pipe_hit_vec);
    end

    // Game state and overlap counter. The count consumes the registered
    // coverage bits, giving the 2-cycle overlap-to-count latency. Frame_Start
    // takes priority, so an increment landing on it is dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hit_d   = hit_q;
        fv_d    = fv_q;
        lose_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                fv_d    = 1'b0;
                if (Start) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (Frame_Start) begin
                    if (fv_q && (count_q >= 8'(HIT_THRESH))) begin
                        state_d = ST_LOSE;
                        lose_d  = 1'b1;
                    end
                    hit_d   = count_q;
                    count_d = '0;
                    fv_d    = 1'b1;
                end else if (fv_q && bird_px_q && pipe_px_q && (count_q != 8'hFF)) begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_LOSE: begin
                if (Ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            bird_l_q  <= '0;
            bird_r_q  <= '0;
            bird_t_q  <= '0;
            bird_b_q  <= '0;
            pipe_l_q  <= '0;
            pipe_r_q  <= '0;
            pipe_b_q  <= '0;
            pipe_t_q  <= '0;
            bird_px_q <= 1'b0;
            pipe_px_q <= 1'b0;
            count_q   <= '0;
            hit_q     <= '0;
            fv_q      <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bird_l_q  <= bird_l_d;
            bird_r_q  <= bird_r_d;
            bird_t_q  <= bird_t_d;
            bird_b_q  <= bird_b_d;
            pipe_l_q  <= pipe_l_d;
            pipe_r_q  <= pipe_r_d;
            pipe_b_q  <= pipe_b_d;
            pipe_t_q  <= pipe_t_d;
            bird_px_q <= bird_px_d;
            pipe_px_q <= pipe_px_d;
            count_q   <= count_d;
            hit_q     <= hit_d;
            fv_q      <= fv_d;
            lose_q    <= lose_d;
        end
    end

    assign Bird_Px    = bird_px_q;
    assign Pipe_Px    = pipe_px_q;
    assign Hit_Count  = hit_q;
    assign Lose_Pulse = lose_q;
    assign Q_Idle     = (state_q == ST_IDLE);
    assign Q_Armed    = (state_q == ST_ARMED);
    assign Q_Lose     = (state_q == ST_LOSE);

endmodule

// File: tb/tb_pixel_collision_detector.sv
// Bench for pixel_collision_detector: scenario table, clamp probe table,
// handshake / reset sequences and randomized frames, all compared against a
// behavioural pixel-level model.
module tb_pixel_collision_detector;

    localparam int HM = 639, VM = 479, BH = 10, PW = 80, TH = 8;

    logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0, Frame_Start = 1'b0;
    logic        inDisplayArea = 1'b0;
    logic [9:0]  CounterX = '0, CounterY = '0, Bird_X = '0, Bird_Y = '0;
    logic [39:0] Pipe_X = '0, Pipe_Top = '0, Pipe_Bot = '0;
    logic        Bird_Px, Pipe_Px, Lose_Pulse, Q_Idle, Q_Armed, Q_Lose;
    logic [7:0]  Hit_Count;

    pixel_collision_detector dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Frame_Start(Frame_Start),
        .inDisplayArea(inDisplayArea), .CounterX(CounterX), .CounterY(CounterY),
        .Bird_X(Bird_X), .Bird_Y(Bird_Y), .Pipe_X(Pipe_X), .Pipe_Top(Pipe_Top),
        .Pipe_Bot(Pipe_Bot), .Bird_Px(Bird_Px), .Pipe_Px(Pipe_Px), .Hit_Count(Hit_Count),
        .Lose_Pulse(Lose_Pulse), .Q_Idle(Q_Idle), .Q_Armed(Q_Armed), .Q_Lose(Q_Lose)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    int checks = 0, errors = 0;

    // ---------------- behavioural model ----------------
    int m_bl, m_br, m_bt, m_bb;
    int m_pl[4], m_pr[4], m_pb[4], m_pt[4];
    int m_st;                    // 0 idle, 1 armed, 2 lose
    int m_cnt, m_hit;
    bit m_fv, m_lose, m_bpx, m_ppx;

    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

    task automatic model_reset();
        m_bl = 0; m_br = 0; m_bt = 0; m_bb = 0;
        for (int i = 0; i < 4; i++) begin m_pl[i] = 0; m_pr[i] = 0; m_pb[i] = 0; m_pt[i] = 0; end
        m_st = 0; m_cnt = 0; m_hit = 0; m_fv = 0; m_lose = 0; m_bpx = 0; m_ppx = 0;
    endtask

    task automatic model_latch();
        int bx, by, px;
        bx = int'(Bird_X); by = int'(Bird_Y);
        m_bl = imax(bx - BH, 0); m_br = imin(bx + BH, HM);
        m_bt = imax(by - BH, 0); m_bb = imin(by + BH, VM);
        for (int i = 0; i < 4; i++) begin
            px = int'(Pipe_X[10*i +: 10]);
            m_pl[i] = px; m_pr[i] = imin(px + PW, HM);
            m_pb[i] = int'(Pipe_Bot[10*i +: 10]); m_pt[i] = int'(Pipe_Top[10*i +: 10]);
        end
    endtask

    task automatic model_edge(input bit st, input bit ack, input bit fs, input bit disp,
                              input int x, input int y);
        bit nb, np, ov, nl;
        ov = m_bpx && m_ppx;
        nb = disp && x >= m_bl && x <= m_br && y >= m_bt && y <= m_bb;
        np = 0;
        for (int i = 0; i < 4; i++)
            if (disp && x >= m_pl[i] && x <= m_pr[i] && y >= m_pb[i] && y <= m_pt[i]) np = 1;
        nl = 0;
        case (m_st)
            0: begin m_cnt = 0; m_fv = 0; if (st) m_st = 1; end
            1: begin
                if (fs) begin
                    nl = m_fv && (m_cnt >= TH);
                    m_hit = m_cnt; m_cnt = 0; m_fv = 1;
                    if (nl) m_st = 2;
                end else if (m_fv && ov) m_cnt = imin(m_cnt + 1, 255);
            end
            default: if (ack) m_st = 0;
        endcase
        m_lose = nl;
        if (fs) model_latch();
        m_bpx = nb; m_ppx = np;
    endtask

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // drive at negedge, clock, then compare at the following negedge
    task automatic step(input bit st, input bit ack, input bit fs, input bit disp,
                        input int x, input int y);
        Start = st; Ack = ack; Frame_Start = fs; inDisplayArea = disp;
        CounterX = 10'(x); CounterY = 10'(y);
        @(posedge Clk);
        model_edge(st, ack, fs, disp, x, y);
        @(negedge Clk);
        chk("bird_px", int'(Bird_Px), int'(m_bpx));
        chk("pipe_px", int'(Pipe_Px), int'(m_ppx));
        chk("hit_count", int'(Hit_Count), m_hit);
        chk("lose_pulse", int'(Lose_Pulse), int'(m_lose));
        chk("state", int'({Q_Lose, Q_Armed, Q_Idle}), 1 << m_st);
    endtask

    task automatic blanks(); step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); endtask
    task automatic fs_step(); step(0, 0, 1, 0, 0, 0); endtask

    task automatic do_reset();
        Reset = 1'b1; Start = 0; Ack = 0; Frame_Start = 0; inDisplayArea = 0;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic set_cfg(input int bx, input int by, input int px, input int pbot, input int ptop);
        Bird_X = 10'(bx); Bird_Y = 10'(by);
        Pipe_X   = {10'd1000, 10'd1000, 10'd1000, 10'(px)};
        Pipe_Bot = {10'd0, 10'd0, 10'd0, 10'(pbot)};
        Pipe_Top = {10'd479, 10'd479, 10'd479, 10'(ptop)};
    endtask

    task automatic scan(input int bx, input int by);
        for (int dy = -15; dy <= 15; dy++)
            for (int dx = -15; dx <= 15; dx++)
                step(0, 0, 0, 1, bx + dx, by + dy);
    endtask

    typedef struct { int bx, by, px, pbot, ptop, hit; bit lose; } scen_t;
    typedef struct { int x, y; bit disp, eb, ep; } probe_t;

    scen_t  sc[6];
    probe_t pr[11];

    initial begin
        sc[0] = '{100, 200, 400,   0, 479,   0, 1'b0};  // clean game
        sc[1] = '{100, 200,  95,   0, 479, 255, 1'b1};  // 336 overlaps, saturates
        sc[2] = '{100, 200, 109, 200, 200,   2, 1'b0};  // tolerance graze
        sc[3] = '{100, 200,  95, 479,   0,   0, 1'b0};  // empty pipe (bot > top)
        sc[4] = '{100, 200, 103, 200, 200,   8, 1'b1};  // exactly threshold
        sc[5] = '{100, 200, 104, 200, 200,   7, 1'b0};  // one below threshold

        pr[0]  = '{  0, 479, 1'b1, 1'b1, 1'b0};
        pr[1]  = '{ 13, 465, 1'b1, 1'b1, 1'b0};
        pr[2]  = '{ 14, 470, 1'b1, 1'b0, 1'b0};
        pr[3]  = '{  5, 464, 1'b1, 1'b0, 1'b0};
        pr[4]  = '{600, 100, 1'b1, 1'b0, 1'b1};
        pr[5]  = '{599, 100, 1'b1, 1'b0, 1'b0};
        pr[6]  = '{639, 479, 1'b1, 1'b0, 1'b1};
        pr[7]  = '{640, 100, 1'b1, 1'b0, 1'b0};
        pr[8]  = '{350, 200, 1'b1, 1'b0, 1'b0};
        pr[9]  = '{  5, 470, 1'b0, 1'b0, 1'b0};
        pr[10] = '{620,   0, 1'b1, 1'b0, 1'b1};

        // reset state
        do_reset();
        chk("rst_idle", int'(Q_Idle), 1);
        chk("rst_armed_lose", int'({Q_Armed, Q_Lose}), 0);
        chk("rst_hit", int'(Hit_Count), 0);
        chk("rst_px", int'({Bird_Px, Pipe_Px, Lose_Pulse}), 0);

        // scenario table: three frames each
        for (int s = 0; s < 6; s++) begin
            do_reset();
            set_cfg(sc[s].bx, sc[s].by, sc[s].px, sc[s].pbot, sc[s].ptop);
            step(1, 0, 0, 0, 0, 0);
            scan(sc[s].bx, sc[s].by); blanks(); fs_step();
            chk($sformatf("sc%0d_f1_hit", s), int'(Hit_Count), 0);
            chk($sformatf("sc%0d_f1_armed", s), int'(Q_Armed), 1);
            scan(sc[s].bx, sc[s].by); blanks(); fs_step();
            chk($sformatf("sc%0d_f2_hit", s), int'(Hit_Count), sc[s].hit);
            chk($sformatf("sc%0d_f2_pulse", s), int'(Lose_Pulse), int'(sc[s].lose));
            chk($sformatf("sc%0d_f2_lose", s), int'(Q_Lose), int'(sc[s].lose));
            scan(sc[s].bx, sc[s].by); blanks(); fs_step();
            chk($sformatf("sc%0d_f3_hit", s), int'(Hit_Count), sc[s].hit);
            chk($sformatf("sc%0d_f3_pulse", s), int'(Lose_Pulse), 0);
            chk($sformatf("sc%0d_f3_armed", s), int'(Q_Armed), int'(!sc[s].lose));
        end

        // clamp and empty-pipe probes
        do_reset();
        Bird_X = 10'd3; Bird_Y = 10'd475;
        Pipe_X   = {10'd1000, 10'd1000, 10'd300, 10'd600};
        Pipe_Bot = {10'd0, 10'd0, 10'd300, 10'd0};
        Pipe_Top = {10'd479, 10'd479, 10'd100, 10'd479};
        step(1, 0, 0, 0, 0, 0);
        fs_step();
        for (int p = 0; p < 11; p++) begin
            step(0, 0, 0, pr[p].disp, pr[p].x, pr[p].y);
            chk($sformatf("probe%0d_bird", p), int'(Bird_Px), int'(pr[p].eb));
            chk($sformatf("probe%0d_pipe", p), int'(Pipe_Px), int'(pr[p].ep));
        end

        // handshake sequence
        do_reset();
        set_cfg(100, 200, 95, 0, 479);
        step(1, 0, 0, 0, 0, 0);
        fs_step();
        step(0, 1, 0, 0, 0, 0);
        chk("ack_in_armed", int'(Q_Armed), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 100 + i, 200);
        blanks(); fs_step();
        chk("hs_pulse", int'(Lose_Pulse), 1);
        chk("hs_lose", int'(Q_Lose), 1);
        chk("hs_hit", int'(Hit_Count), 10);
        step(0, 0, 0, 0, 0, 0);
        chk("hs_pulse_one_cycle", int'(Lose_Pulse), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("start_in_lose", int'(Q_Lose), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("ack_to_idle", int'(Q_Idle), 1);
        step(1, 1, 0, 0, 0, 0);
        chk("start_ack_idle", int'(Q_Armed), 1);

        // reset mid-line with a live count of 5
        do_reset();
        set_cfg(100, 200, 95, 0, 479);
        step(1, 0, 0, 0, 0, 0);
        fs_step();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 100 + i, 200);
        blanks(); fs_step();
        chk("mr_hit5", int'(Hit_Count), 5);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 100 + i, 200);
        #2 Reset = 1'b1;
        #1;
        chk("mr_async_px", int'({Bird_Px, Pipe_Px, Lose_Pulse}), 0);
        chk("mr_async_hit", int'(Hit_Count), 0);
        chk("mr_async_state", int'({Q_Lose, Q_Armed, Q_Idle}), 1);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        fs_step();
        chk("mr_clean_f1", int'(Hit_Count), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 100 + i, 200);
        blanks(); fs_step();
        chk("mr_clean_f2", int'(Hit_Count), 3);

        // randomized frames against the model
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 14; f++) begin
            int bx, by;
            bx = int'($urandom_range(0, 700));
            by = int'($urandom_range(0, 500));
            Bird_X = 10'(bx); Bird_Y = 10'(by);
            Pipe_X   = {10'($urandom), 10'($urandom), 10'($urandom),
                        10'(imin(imax(bx + int'($urandom_range(0, 30)) - 20, 0), 1023))};
            Pipe_Bot = {10'($urandom), 10'($urandom), 10'($urandom),
                        10'(imax(by - int'($urandom_range(0, 15)), 0))};
            Pipe_Top = {10'($urandom), 10'($urandom), 10'($urandom),
                        10'(by + int'($urandom_range(0, 15)) - (($urandom_range(0, 5) == 0) ? 20 : 0))};
            for (int c = 0; c < 150; c++) begin
                int x, y;
                x = imin(imax(bx + int'($urandom_range(0, 30)) - 15, 0), 1023);
                y = imin(imax(by + int'($urandom_range(0, 30)) - 15, 0), 1023);
                step(($urandom_range(0, 40) == 0), ($urandom_range(0, 40) == 0), 0,
                     ($urandom_range(0, 7) != 0), x, y);
            end
            blanks(); fs_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
